// File: rtl/alu_ctrl_issue.sv
// ALU control decode with a one-entry issue register and an optional 32-cycle shift-add multiplier.
// Define ALUCTL_MULT_EN to enable MULT/MULTU and the hi/lo product registers.

module alu_ctrl_issue (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  aluop,
   input  logic [5:0]  funct,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] data_a,
   input  logic [31:0] data_b,
   output logic        op_valid,
   input  logic        op_ready,
   output logic [3:0]  operation,
   output logic        illegal,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        mult_done
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

`ifdef ALUCTL_MULT_EN
   typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, MUL = 2'd2} state_t;
`else
   typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1} state_t;
`endif

   state_t     state;
   state_t     next_state;
   logic       accept;
   logic       drain;
   logic       alu_accept;
   logic [3:0] dec_op;
   logic       dec_ill;

`ifdef ALUCTL_MULT_EN
   logic        dec_mul;
   logic        dec_signed;
   logic [5:0]  count;
   logic [63:0] prod;
   logic [31:0] mcand;
   logic        negate;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [63:0] prod_step;
   logic [63:0] prod_final;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   // Adds the multiplicand into the upper half when the current multiplier bit is set, then shifts right.
   function automatic logic [63:0] mul_step(input logic [63:0] p, input logic [31:0] m);
      logic [32:0] sum;
      sum = {1'b0, p[63:32]} + {1'b0, (p[0] ? m : 32'd0)};
      return {sum, p[31:1]};
   endfunction
`endif

   assign accept = req_valid & req_ready;
   assign drain  = op_valid & op_ready;

   always_comb begin
      dec_op  = OP_ADD;
      dec_ill = 1'b0;
`ifdef ALUCTL_MULT_EN
      dec_mul    = 1'b0;
      dec_signed = 1'b0;
`endif
      case (aluop)
         2'b00: dec_op = OP_ADD;
         2'b01: dec_op = OP_SUB;
         2'b10: begin
            case (funct)
               6'b100000: dec_op = OP_ADD;
               6'b100010: dec_op = OP_SUB;
               6'b100100: dec_op = OP_AND;
               6'b100101: dec_op = OP_OR;
               6'b101010: dec_op = OP_SLT;
               6'b100111: dec_op = OP_NOR;
`ifdef ALUCTL_MULT_EN
               6'b011000: begin
                  dec_mul    = 1'b1;
                  dec_signed = 1'b1;
               end
               6'b011001: dec_mul = 1'b1;
`endif
               default:   dec_ill = 1'b1;
            endcase
         end
         default: dec_ill = 1'b1;
      endcase
   end

`ifdef ALUCTL_MULT_EN
   assign alu_accept = accept & ~dec_mul;
`else
   assign alu_accept = accept;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= next_state;
      end
   end

   // A request is only ever accepted while the issue register is empty or draining, so accept implies a free slot.
   always_comb begin
      next_state = state;
      case (state)
         EMPTY: begin
            if (accept) begin
               next_state = FULL;
`ifdef ALUCTL_MULT_EN
               if (dec_mul) next_state = MUL;
`endif
            end
         end
         FULL: begin
            if (accept) begin
               next_state = FULL;
`ifdef ALUCTL_MULT_EN
               if (dec_mul) next_state = MUL;
`endif
            end else if (drain) begin
               next_state = EMPTY;
            end
         end
`ifdef ALUCTL_MULT_EN
         MUL: begin
            if (count == 6'd32) next_state = EMPTY;
         end
`endif
         default: next_state = EMPTY;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      op_valid  = 1'b0;
      mult_done = 1'b0;
      case (state)
         EMPTY: req_ready = 1'b1;
         FULL: begin
            req_ready = op_ready;
            op_valid  = 1'b1;
         end
`ifdef ALUCTL_MULT_EN
         MUL: mult_done = (count == 6'd32);
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         operation <= OP_ADD;
         illegal   <= 1'b0;
      end else if (alu_accept) begin
         operation <= dec_op;
         illegal   <= dec_ill;
      end
   end

`ifdef ALUCTL_MULT_EN
   // Signed multiply runs on magnitudes; the sign is restored when the last iteration is written to hi/lo.
   assign abs_a      = (dec_signed && data_a[31]) ? (32'd0 - data_a) : data_a;
   assign abs_b      = (dec_signed && data_b[31]) ? (32'd0 - data_b) : data_b;
   assign prod_step  = mul_step(prod, mcand);
   assign prod_final = negate ? (64'd0 - prod_step) : prod_step;

   // The first iteration is folded into the accept edge so the 32nd lands one cycle before leaving MUL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod   <= 64'd0;
         mcand  <= 32'd0;
         negate <= 1'b0;
         count  <= 6'd0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
      end else if (accept && dec_mul) begin
         prod   <= mul_step({32'd0, abs_b}, abs_a);
         mcand  <= abs_a;
         negate <= dec_signed & (data_a[31] ^ data_b[31]);
         count  <= 6'd1;
      end else if (state == MUL) begin
         if (count == 6'd31) begin
            hi_q  <= prod_final[63:32];
            lo_q  <= prod_final[31:0];
            count <= 6'd32;
         end else if (count == 6'd32) begin
            count <= 6'd0;
         end else begin
            prod  <= prod_step;
            count <= count + 6'd1;
         end
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;
`else
   logic unused_operands;

   // Operands only feed the multiplier, which is absent in this build.
   assign unused_operands = ^{data_a, data_b};
   assign hi = 32'd0;
   assign lo = 32'd0;
`endif

endmodule

// File: doc/alu_ctrl_issue.md
ALU_CTRL_ISSUE -- requirements
Module: alu_ctrl_issue

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 aluop  input  2  main-control ALU class: 00 load/store, 01 branch, 10 R-type, 11 reserved.
REQ-004 funct  input  6  instruction funct field; meaningful only when aluop=10.
REQ-005 req_valid  input  1  request present on aluop/funct/data_a/data_b.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 data_a, data_b  input  32 each  multiply operands, sampled on acceptance.
REQ-008 op_valid  output  1  operation/illegal hold a decoded result.
REQ-009 op_ready  input  1  ALU-side consumer takes the decoded result.
REQ-010 operation  output  4  ALU operation code: 0000 AND, 0001 OR, 0010 add, 0110 sub, 0111 slt, 1100 nor.
REQ-011 illegal  output  1  accepted request had no valid encoding.
REQ-012 hi, lo  output  32 each  product upper and lower words.
REQ-013 mult_done  output  1  one-cycle pulse when hi/lo update.

Function
REQ-014 Decode: aluop 00 -> 0010; 01 -> 0110; 10 with funct 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 100111 -> 1100.
REQ-015 Any other aluop/funct (including aluop 11) SHALL produce operation 0010 with illegal=1.
REQ-016 States: EMPTY, FULL, MUL; transfer occurs on a cycle with req_valid&req_ready (accept) or op_valid&op_ready (drain).
REQ-017 req_ready = 1 in EMPTY, = op_ready in FULL, = 0 in MUL.
REQ-018 Non-multiply accept: registered decode appears with op_valid=1 the cycle after acceptance (latency 1); state -> FULL.
REQ-019 FULL: operation/illegal held stable while op_ready=0; drain with no accept -> EMPTY; simultaneous drain and accept -> FULL with new result, no bubble.
REQ-020 op_valid=1 only in FULL; operation/illegal hold last value otherwise.
REQ-021 Multiply accept (aluop=10, funct 011000 MULT signed, 011001 MULTU unsigned): latch operands, state -> MUL, op_valid not asserted for this request.
REQ-022 MUL: one shift-add iteration per cycle, 32 iterations; mult_done pulses in the 32nd cycle after acceptance, hi/lo take the full 64-bit product that same cycle; state -> EMPTY the next cycle.
REQ-023 MULT: two's-complement 64-bit product (e.g., -1 x 2 -> hi=FFFFFFFF, lo=FFFFFFFE); MULTU: unsigned product.
REQ-024 hi/lo change only at mult_done; they hold between multiplies and through non-multiply traffic.
REQ-025 Multiply accepted from FULL (same-cycle drain) is legal; from FULL without drain is impossible (req_ready=0).

Reset
REQ-026 rst_n low SHALL immediately force state EMPTY, op_valid=0, operation=0010, illegal=0, hi=0, lo=0, mult_done=0, iteration counter=0.
REQ-027 Reset during MUL SHALL abandon the multiply with no mult_done pulse and hi/lo=0.
REQ-028 After rst_n rises, req_ready=1 on the first clock edge.

Configuration
REQ-029 Macro ALUCTL_MULT_EN defined: MULT/MULTU supported per REQ-021..REQ-025.
REQ-030 Macro ALUCTL_MULT_EN undefined: funct 011000/011001 decode as illegal per REQ-015, MUL state absent, hi=lo=0 and mult_done=0 constantly.

Verification
REQ-031 Reset, then aluop=10 funct=100111 req_valid=1 op_ready=1 -> next cycle op_valid=1, operation=1100, illegal=0.
REQ-032 Hold op_ready=0 with op_valid=1, change inputs -> req_ready=0, operation unchanged for 5 cycles; raise op_ready with new aluop=01 request -> next cycle operation=0110, op_valid=1.
REQ-033 aluop=11 accepted -> op_valid=1, operation=0010, illegal=1; aluop=10 funct=000000 -> same.
REQ-034 MULT data_a=FFFFFFFF data_b=00000002 (macro defined) -> req_ready=0 for 32 cycles, mult_done at cycle 32, hi=FFFFFFFF lo=FFFFFFFE; MULTU same operands -> hi=00000001 lo=FFFFFFFE.
REQ-035 Drop rst_n 10 cycles into a multiply -> hi=lo=0 immediately, no mult_done, req_ready=1 after release.
REQ-036 Macro undefined: MULT request -> op_valid=1 next cycle, illegal=1, mult_done never asserted.
